// File: rtl/score_bcd_counter_pkg.sv
// score_pkg: BCD digit type, digit adder, digit-wise compare and a decimal-to-BCD helper
package score_pkg;
    localparam int DIGIT_W = 4;
    localparam int MAX_DIGITS = 4;
    localparam int FW = MAX_DIGITS * DIGIT_W;
    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    function automatic logic [DIGIT_W:0] bcd_digit_add(input bcd_digit_t a, input bcd_digit_t b, input logic cin);
        logic [DIGIT_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        return (s > 5'd9) ? {1'b1, s[3:0] - 4'd10} : s;
    endfunction

    // Only the low n digits take part; the first differing digit from the top decides
    function automatic logic bcd_ge(input logic [FW-1:0] a, input logic [FW-1:0] b, input int n);
        logic ge, done;
        ge = 1'b1;
        done = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--)
            if (!done && i < n && a[i*DIGIT_W +: DIGIT_W] != b[i*DIGIT_W +: DIGIT_W]) begin
                ge = a[i*DIGIT_W +: DIGIT_W] > b[i*DIGIT_W +: DIGIT_W];
                done = 1'b1;
            end
        return ge;
    endfunction

    function automatic logic [FW-1:0] to_bcd(input int v);
        logic [FW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i*DIGIT_W +: DIGIT_W] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction
endpackage

// File: rtl/score_bcd_counter_if.sv
// score_bcd_counter_if: game event inputs and score/display outputs of the score counter
interface score_bcd_counter_if import score_pkg::*; #(
    parameter int NUM_DIGITS = 2,
    parameter int BONUS_W = 4
);
    logic CLEAR;
    logic REACHED_TARGET;
    logic BONUS_VALID;
    logic [BONUS_W-1:0] BONUS_AMT;
    logic [DIGIT_W*NUM_DIGITS-1:0] SCORE_BCD;
    logic MAX_REACHED;
    logic WIN_PULSE;
    logic [NUM_DIGITS-1:0] SCAN_SEL;
    bcd_digit_t SCAN_DIGIT;
    logic [DIGIT_W*NUM_DIGITS-1:0] HISCORE_BCD;

    modport master(
        output CLEAR, REACHED_TARGET, BONUS_VALID, BONUS_AMT,
        input SCORE_BCD, MAX_REACHED, WIN_PULSE, SCAN_SEL, SCAN_DIGIT, HISCORE_BCD
    );
    modport slave(
        input CLEAR, REACHED_TARGET, BONUS_VALID, BONUS_AMT,
        output SCORE_BCD, MAX_REACHED, WIN_PULSE, SCAN_SEL, SCAN_DIGIT, HISCORE_BCD
    );
endinterface

// File: rtl/score_bcd_counter_scan.sv
// score_digit_scan: free-running prescaler and digit index driving a one-hot select and the selected BCD digit
module score_digit_scan import score_pkg::*; #(
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV = 16
) (
    input logic CLK,
    input logic RESET_N,
    input logic [DIGIT_W*NUM_DIGITS-1:0] score_i,
    output logic [NUM_DIGITS-1:0] scan_sel_o,
    output bcd_digit_t scan_digit_o
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    logic [PW-1:0] pre_q, pre_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    bcd_digit_t dig_q, dig_d;

    // score_i is the next score, so the digit lines up with SCORE_BCD in the same cycle
    always_comb begin
        pre_d = (pre_q == PW'(SCAN_DIV - 1)) ? '0 : pre_q + 1'b1;
        idx_d = (pre_q != PW'(SCAN_DIV - 1)) ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        sel_d = NUM_DIGITS'(1) << idx_d;
        dig_d = score_i[idx_d*DIGIT_W +: DIGIT_W];
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pre_q <= '0;
            idx_q <= '0;
            sel_q <= NUM_DIGITS'(1);
            dig_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            dig_q <= dig_d;
        end
    end

    assign scan_sel_o = sel_q;
    assign scan_digit_o = dig_q;
endmodule

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: saturating BCD score with bonus adds, win pulse and digit scanner.
// Define SCORE_HISCORE_EN to build the high-score register; otherwise HISCORE_BCD is 0.
module score_bcd_counter import score_pkg::*; #(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_SCORE = 10,
    parameter int BONUS_W = 4,
    parameter int SCAN_DIV = 16
) (
    input logic CLK,
    input logic RESET_N,
    score_bcd_counter_if.slave bus
);
    localparam int SW = DIGIT_W * NUM_DIGITS;
    localparam logic [SW-1:0] MAX_BCD = SW'(to_bcd(MAX_SCORE));
    logic [SW-1:0] score_q, score_d, sum, inc_bcd;
    logic [NUM_DIGITS:0] carry;
    logic [4:0] inc;
    logic ovf, at_max, win_q, win_d;

    assign inc = 5'(bus.REACHED_TARGET) + (bus.BONUS_VALID ? 5'(bus.BONUS_AMT) : 5'd0);
    assign inc_bcd = SW'(to_bcd(int'(inc)));
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add
        assign {carry[i+1], sum[i*DIGIT_W +: DIGIT_W]} =
            bcd_digit_add(score_q[i*DIGIT_W +: DIGIT_W], inc_bcd[i*DIGIT_W +: DIGIT_W], carry[i]);
    end

    // An increment wider than the score, or a carry off the top digit, is always past MAX_SCORE
    assign ovf = carry[NUM_DIGITS] || int'(inc) >= 10**NUM_DIGITS;
    assign at_max = score_q == MAX_BCD;

    always_comb begin
        score_d = bus.CLEAR ? '0 : at_max ? score_q :
                  (ovf || bcd_ge(FW'(sum), FW'(MAX_BCD), NUM_DIGITS)) ? MAX_BCD : sum;
        win_d = !bus.CLEAR && !at_max && score_d == MAX_BCD;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            score_q <= '0;
            win_q <= 1'b0;
        end else begin
            score_q <= score_d;
            win_q <= win_d;
        end
    end

    assign bus.SCORE_BCD = score_q;
    assign bus.MAX_REACHED = at_max;
    assign bus.WIN_PULSE = win_q;

`ifdef SCORE_HISCORE_EN
    logic [SW-1:0] hi_q, hi_d;
    assign hi_d = bcd_ge(FW'(score_q), FW'(hi_q), NUM_DIGITS) ? score_q : hi_q;
    always_ff @(posedge CLK) begin
        if (!RESET_N) hi_q <= '0;
        else hi_q <= hi_d;
    end
    assign bus.HISCORE_BCD = hi_q;
`else
    assign bus.HISCORE_BCD = '0;
`endif

    score_digit_scan #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) u_scan (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .score_i(score_d),
        .scan_sel_o(bus.SCAN_SEL),
        .scan_digit_o(bus.SCAN_DIGIT)
    );
endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter: directed stimulus with an integer score model compared every cycle
module tb_score_bcd_counter;
    localparam int ND = 2;
    localparam int MX = 10;
    localparam int BW = 4;
    localparam int SD = 16;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int total = 0;
    int passed = 0;
    int m_score, m_hi, m_cyc, m_inc, m_next, m_idx;
    logic m_win;
    bit live = 0;

    always #5 CLK = ~CLK;

    score_bcd_counter_if #(.NUM_DIGITS(ND), .BONUS_W(BW)) bus ();

    score_bcd_counter #(.NUM_DIGITS(ND), .MAX_SCORE(MX), .BONUS_W(BW), .SCAN_DIV(SD)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    function automatic logic [15:0] bcd2(input int v);
        return 16'((v / 10) * 16 + v % 10);
    endfunction

    function automatic int hi_exp();
`ifdef SCORE_HISCORE_EN
        return m_hi;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: score is a plain integer clipped at MX; scan index follows the cycle count since reset
    always @(posedge CLK) begin
        if (!RESET_N) begin
            m_score = 0;
            m_hi = 0;
            m_cyc = 0;
            m_win = 0;
            live = 1;
        end else begin
            if (m_score > m_hi) m_hi = m_score;
            m_inc = int'(bus.REACHED_TARGET) + (bus.BONUS_VALID ? int'(bus.BONUS_AMT) : 0);
            if (bus.CLEAR) begin
                m_score = 0;
                m_win = 0;
            end else if (m_score == MX) begin
                m_win = 0;
            end else begin
                m_next = (m_score + m_inc > MX) ? MX : m_score + m_inc;
                m_win = (m_next == MX);
                m_score = m_next;
            end
            m_cyc++;
        end
    end

    always @(negedge CLK) begin
        if (live) begin
            m_idx = (m_cyc / SD) % ND;
            chk("score", 16'(bus.SCORE_BCD), bcd2(m_score));
            chk("max_reached", 16'(bus.MAX_REACHED), 16'(m_score == MX));
            chk("win_pulse", 16'(bus.WIN_PULSE), 16'(m_win));
            chk("scan_sel", 16'(bus.SCAN_SEL), 16'(1 << m_idx));
            chk("scan_digit", 16'(bus.SCAN_DIGIT), 16'((m_idx == 0 ? m_score : m_score / 10) % 10));
            chk("hiscore", 16'(bus.HISCORE_BCD), bcd2(hi_exp()));
        end
    end

    task automatic ev(input logic rt, input logic bv, input logic [3:0] amt, input logic clr);
        bus.REACHED_TARGET = rt;
        bus.BONUS_VALID = bv;
        bus.BONUS_AMT = amt;
        bus.CLEAR = clr;
        @(negedge CLK);
        bus.REACHED_TARGET = 1'b0;
        bus.BONUS_VALID = 1'b0;
        bus.BONUS_AMT = '0;
        bus.CLEAR = 1'b0;
    endtask

    initial begin
        bus.REACHED_TARGET = 1'b0;
        bus.BONUS_VALID = 1'b0;
        bus.BONUS_AMT = '0;
        bus.CLEAR = 1'b0;
        repeat (2) @(negedge CLK);
        chk("lit_rst_score", 16'(bus.SCORE_BCD), 16'h0000);
        chk("lit_rst_sel", 16'(bus.SCAN_SEL), 16'h0001);
        chk("lit_rst_win", 16'(bus.WIN_PULSE), 16'h0000);
        RESET_N = 1'b1;
        repeat (16) @(negedge CLK);
        chk("lit_sel_16", 16'(bus.SCAN_SEL), 16'h0002);
        repeat (16) @(negedge CLK);
        chk("lit_sel_32", 16'(bus.SCAN_SEL), 16'h0001);
        repeat (9) ev(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_nine", 16'(bus.SCORE_BCD), 16'h0009);
        chk("lit_nine_max", 16'(bus.MAX_REACHED), 16'h0000);
        ev(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_carry", 16'(bus.SCORE_BCD), 16'h0010);
        chk("lit_carry_max", 16'(bus.MAX_REACHED), 16'h0001);
        chk("lit_win_on", 16'(bus.WIN_PULSE), 16'h0001);
        @(negedge CLK);
        chk("lit_win_off", 16'(bus.WIN_PULSE), 16'h0000);
        ev(1'b0, 1'b0, 4'd0, 1'b1);
        chk("lit_clear", 16'(bus.SCORE_BCD), 16'h0000);
        ev(1'b0, 1'b1, 4'd7, 1'b0);
        chk("lit_bonus7", 16'(bus.SCORE_BCD), 16'h0007);
        ev(1'b0, 1'b1, 4'd5, 1'b0);
        chk("lit_bonus_sat", 16'(bus.SCORE_BCD), 16'h0010);
        chk("lit_bonus_win", 16'(bus.WIN_PULSE), 16'h0001);
        repeat (3) ev(1'b1, 1'b1, 4'd2, 1'b0);
        chk("lit_hold", 16'(bus.SCORE_BCD), 16'h0010);
        chk("lit_no_rewin", 16'(bus.WIN_PULSE), 16'h0000);
        ev(1'b0, 1'b0, 4'd0, 1'b1);
        ev(1'b0, 1'b1, 4'd3, 1'b0);
        ev(1'b1, 1'b1, 4'd4, 1'b0);
        chk("lit_simul", 16'(bus.SCORE_BCD), 16'h0008);
        ev(1'b0, 1'b0, 4'd0, 1'b1);
        ev(1'b0, 1'b1, 4'd5, 1'b0);
        ev(1'b1, 1'b0, 4'd0, 1'b1);
        chk("lit_clear_prio", 16'(bus.SCORE_BCD), 16'h0000);
        chk("lit_clear_nowin", 16'(bus.WIN_PULSE), 16'h0000);
        ev(1'b1, 1'b1, 4'd15, 1'b0);
        chk("lit_inc16", 16'(bus.SCORE_BCD), 16'h0010);
        chk("lit_inc16_win", 16'(bus.WIN_PULSE), 16'h0001);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        chk("lit_rst2_score", 16'(bus.SCORE_BCD), 16'h0000);
        chk("lit_rst2_hi", 16'(bus.HISCORE_BCD), 16'h0000);
        chk("lit_rst2_sel", 16'(bus.SCAN_SEL), 16'h0001);
        ev(1'b0, 1'b1, 4'd6, 1'b0);
        ev(1'b0, 1'b0, 4'd0, 1'b1);
        ev(1'b0, 1'b1, 4'd4, 1'b0);
        @(negedge CLK);
        chk("lit_score4", 16'(bus.SCORE_BCD), 16'h0004);
`ifdef SCORE_HISCORE_EN
        chk("lit_hiscore", 16'(bus.HISCORE_BCD), 16'h0006);
`else
        chk("lit_hiscore", 16'(bus.HISCORE_BCD), 16'h0000);
`endif
        repeat (40) @(negedge CLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
